// File: rtl/regfile_scoreboard_pkg.sv
// ============================================================================
// regfile_scoreboard_pkg
//   Shared definitions for the GPR file / pending-writer scoreboard:
//   reset-enable level, boolean constants and default geometry.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_scoreboard_pkg;

  // Level of the reset input that clears state
  localparam logic REST_EN = 1'b1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Default register file geometry
  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int IDX_W  = $clog2(REG_N);
  localparam int CNT_W  = 2;

endpackage : regfile_scoreboard_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard_reg_busy_cnt.sv
// ============================================================================
// regfile_scoreboard_reg_busy_cnt  (reg_busy_cnt)
//   Pending-writer counter for one register: saturating up/down counter with a
//   synchronous clear used by pipeline flush. An increment and a decrement in
//   the same cycle cancel. Decrement at zero holds zero.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard_reg_busy_cnt
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ZERO = '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then net change of issue/retire, saturating both ways
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = C_ZERO;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != C_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != C_ZERO) cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, asynchronously cleared
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i == REST_EN) cnt_q <= C_ZERO;
    else                    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : regfile_scoreboard_reg_busy_cnt

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
//   Architectural GPR file with per-register pending-writer scoreboard.
//   One WB write per cycle (never stalls), two combinational read ports with
//   RAW busy flags, issue back-pressure on counter saturation, flush of all
//   pending writers and a sticky retire-underflow error.
//   Optional macro REGFILE_BYPASS_EN: same-cycle WB-to-read forwarding and busy
//   suppression on the final retire.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = regfile_scoreboard_pkg::DATA_W,
  parameter int REG_N  = regfile_scoreboard_pkg::REG_N,
  parameter int CNT_W  = regfile_scoreboard_pkg::CNT_W,
  parameter int IDX_W  = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // WB write interface
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic              wb_wen_i,
  input  logic [IDX_W-1:0]  wb_windex_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  // ID issue interface
  input  logic              iss_valid_i,
  output logic              iss_ready_o,
  input  logic              iss_wen_i,
  input  logic [IDX_W-1:0]  iss_windex_i,
  // Read ports
  input  logic [IDX_W-1:0]  rs1_index_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic              rs1_busy_o,
  input  logic [IDX_W-1:0]  rs2_index_i,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs2_busy_o,
  // Control / status
  input  logic              flush_i,
  output logic              err_underflow_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_R0  = '0;

  logic [DATA_W-1:0] mem_q [REG_N];
  logic [CNT_W-1:0]  cnt   [REG_N];
  logic              err_q;
  logic              err_d;

  logic wr_fire;
  logic iss_fire;
  logic same_reg;

  assign wb_ready_o  = TRUE;
  assign iss_ready_o = ~(iss_wen_i & (cnt[iss_windex_i] == C_CNT_MAX));

  assign wr_fire  = wb_valid_i & wb_ready_o & wb_wen_i & (wb_windex_i != C_IDX_R0);
  assign iss_fire = iss_valid_i & iss_ready_o & iss_wen_i & (iss_windex_i != C_IDX_R0);
  // Issue and retire to the same register cancel out in the counter
  assign same_reg = iss_fire & wr_fire & (iss_windex_i == wb_windex_i);

  // r0 has no writer tracking
  assign cnt[0] = '0;

  for (genvar gi = 1; gi < REG_N; gi++) begin : g_cnt
    regfile_scoreboard_reg_busy_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (iss_fire & (iss_windex_i == IDX_W'(gi))),
      .dec_i   (wr_fire  & (wb_windex_i  == IDX_W'(gi))),
      .clr_i   (flush_i),
      .cnt_o   (cnt[gi])
    );
  end

  // Register array: WB writes land regardless of flush
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i == REST_EN) begin
      for (int i = 0; i < REG_N; i++) mem_q[i] <= '0;
    end else if (wr_fire) begin
      mem_q[wb_windex_i] <= wb_wdata_i;
    end
  end

  // Underflow: a real retire against an empty counter, ignored under flush
  always_comb begin
    err_d = err_q;
    if (wr_fire && !flush_i && !same_reg && (cnt[wb_windex_i] == '0)) err_d = TRUE;
  end

  // Sticky error flag, only reset clears it
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i == REST_EN) err_q <= FALSE;
    else                    err_q <= err_d;
  end

  assign err_underflow_o = err_q;

  // Read port 1: array lookup, r0 forced to zero, optional WB forwarding
  always_comb begin
    rs1_data_o = (rs1_index_i == C_IDX_R0) ? '0 : mem_q[rs1_index_i];
    rs1_busy_o = (cnt[rs1_index_i] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (rs1_index_i == wb_windex_i)) begin
      rs1_data_o = wb_wdata_i;
      if ((cnt[rs1_index_i] == C_CNT_ONE) && !same_reg) rs1_busy_o = FALSE;
    end
`endif
  end

  // Read port 2: array lookup, r0 forced to zero, optional WB forwarding
  always_comb begin
    rs2_data_o = (rs2_index_i == C_IDX_R0) ? '0 : mem_q[rs2_index_i];
    rs2_busy_o = (cnt[rs2_index_i] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (rs2_index_i == wb_windex_i)) begin
      rs2_data_o = wb_wdata_i;
      if ((cnt[rs2_index_i] == C_CNT_ONE) && !same_reg) rs2_busy_o = FALSE;
    end
`endif
  end

endmodule : regfile_scoreboard

`default_nettype wire
